// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs the EX/MEM load/store on a valid/ready data bus,
// stalls upstream while busy, resolves branches and holds the MEM/WB register.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_Read_EX_MEM,
  input  logic        Mem_Write_EX_MEM,
  input  logic        PcSrc_EX_MEM,
  input  logic        zero_EX_MEM,
  input  logic        Mem_to_Reg_EX_MEM,
  input  logic        Reg_Write_EX_MEM,
  input  logic [31:0] PC_Branch_EX_MEM,
  input  logic [31:0] result_EX_MEM,
  input  logic [31:0] Write_Data_EX_MEM,
  input  logic [4:0]  rd_EX_MEM,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        Reg_Write_MEM_WB,
  output logic        Mem_to_Reg_MEM_WB,
  output logic [31:0] read_data_MEM_WB,
  output logic [31:0] result_MEM_WB,
  output logic [4:0]  rd_MEM_WB,
  output logic        mem_fault
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             fault;
  logic [31:0]      rdata_cap;
  logic             mem_op, misaligned, timeout, in_done;

  assign mem_op        = Mem_Read_EX_MEM | Mem_Write_EX_MEM;
  assign misaligned    = |result_EX_MEM[1:0];
  assign timeout       = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign in_done       = (state == DONE);
  assign mem_fault     = in_done & fault;
  assign branch_taken  = PcSrc_EX_MEM & zero_EX_MEM;
  assign branch_target = PC_Branch_EX_MEM;

  always_comb begin
    state_nxt      = state;
    stall_mem      = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_wdata     = '0;
    case (state)
      IDLE: if (mem_op) begin
        stall_mem = 1'b1;
        state_nxt = misaligned ? DONE : REQ;
      end
      REQ: begin
        stall_mem      = 1'b1;
        dmem_req_valid = 1'b1;
        dmem_we        = Mem_Write_EX_MEM;
        dmem_addr      = result_EX_MEM;
        dmem_wdata     = Write_Data_EX_MEM;
        // stores are posted: no response phase
        if (dmem_req_ready) state_nxt = Mem_Write_EX_MEM ? DONE : WAIT;
      end
      WAIT: begin
        stall_mem = 1'b1;
        if (dmem_rsp_valid || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      fault             <= 1'b0;
      rdata_cap         <= '0;
      Reg_Write_MEM_WB  <= 1'b0;
      Mem_to_Reg_MEM_WB <= 1'b0;
      read_data_MEM_WB  <= '0;
      result_MEM_WB     <= '0;
      rd_MEM_WB         <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (mem_op) begin
          fault     <= misaligned;
          rdata_cap <= '0;
        end
        REQ:  if (dmem_req_ready) cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          // a response on the last cycle beats the timeout
          if (dmem_rsp_valid) rdata_cap <= dmem_rdata;
          else if (timeout) begin
            rdata_cap <= '0;
            fault     <= 1'b1;
          end
        end
        DONE:    fault <= 1'b0;
        default: ;
      endcase

      if (stall_mem) begin
        Reg_Write_MEM_WB  <= 1'b0;
        Mem_to_Reg_MEM_WB <= 1'b0;
        rd_MEM_WB         <= '0;
        result_MEM_WB     <= '0;
        read_data_MEM_WB  <= '0;
      end else begin
        Reg_Write_MEM_WB  <= Reg_Write_EX_MEM & ~(in_done & fault);
        Mem_to_Reg_MEM_WB <= Mem_to_Reg_EX_MEM;
        rd_MEM_WB         <= rd_EX_MEM;
        result_MEM_WB     <= result_EX_MEM;
        read_data_MEM_WB  <= (in_done && Mem_Read_EX_MEM) ? rdata_cap : '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed cases plus randomized ops against a
// transaction-level model (stall length, fault, bus requests, MEM/WB contents).
module tb_mem_stage_ctrl;
  localparam int TO = 64;

  logic        clk = 1'b0, rst;
  logic        Mem_Read_EX_MEM, Mem_Write_EX_MEM, PcSrc_EX_MEM, zero_EX_MEM;
  logic        Mem_to_Reg_EX_MEM, Reg_Write_EX_MEM;
  logic [31:0] PC_Branch_EX_MEM, result_EX_MEM, Write_Data_EX_MEM;
  logic [4:0]  rd_EX_MEM;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_mem, branch_taken, Reg_Write_MEM_WB, Mem_to_Reg_MEM_WB, mem_fault;
  logic [31:0] branch_target, read_data_MEM_WB, result_MEM_WB;
  logic [4:0]  rd_MEM_WB;

  int checks = 0, errors = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .Mem_Read_EX_MEM(Mem_Read_EX_MEM), .Mem_Write_EX_MEM(Mem_Write_EX_MEM),
    .PcSrc_EX_MEM(PcSrc_EX_MEM), .zero_EX_MEM(zero_EX_MEM),
    .Mem_to_Reg_EX_MEM(Mem_to_Reg_EX_MEM), .Reg_Write_EX_MEM(Reg_Write_EX_MEM),
    .PC_Branch_EX_MEM(PC_Branch_EX_MEM), .result_EX_MEM(result_EX_MEM),
    .Write_Data_EX_MEM(Write_Data_EX_MEM), .rd_EX_MEM(rd_EX_MEM),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .stall_mem(stall_mem), .branch_taken(branch_taken), .branch_target(branch_target),
    .Reg_Write_MEM_WB(Reg_Write_MEM_WB), .Mem_to_Reg_MEM_WB(Mem_to_Reg_MEM_WB),
    .read_data_MEM_WB(read_data_MEM_WB), .result_MEM_WB(result_MEM_WB),
    .rd_MEM_WB(rd_MEM_WB), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bundle();
    Mem_Read_EX_MEM = 0; Mem_Write_EX_MEM = 0; PcSrc_EX_MEM = 0; zero_EX_MEM = 0;
    Mem_to_Reg_EX_MEM = 0; Reg_Write_EX_MEM = 0; PC_Branch_EX_MEM = 0;
    result_EX_MEM = 0; Write_Data_EX_MEM = 0; rd_EX_MEM = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
  endtask

  // One instruction. A = REQ cycles before ready, R = WAIT cycles before response.
  task automatic run_op(input logic rd_op, input logic wr_op, input logic rw, input logic m2r,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int A, input int R, input logic [31:0] rdata);
    int req_c = 0, wait_c = 0, stalls = 0, accepts = 0, exp_stalls;
    bit acc = 0, done = 0, exp_mem, mis, exp_fault;
    logic pcs, zr;
    logic [31:0] pcb;
    exp_mem   = rd_op | wr_op;
    mis       = |addr[1:0];
    exp_fault = exp_mem && (mis || (rd_op && R >= TO));
    if (!exp_mem)  exp_stalls = 0;
    else if (mis)  exp_stalls = 1;
    else           exp_stalls = 2 + A + (rd_op ? ((R + 1 < TO) ? R + 1 : TO) : 0);
    pcs = exp_mem ? 1'b0 : 1'($urandom_range(0, 1));
    zr  = 1'($urandom_range(0, 1));
    pcb = $urandom;
    Mem_Read_EX_MEM = rd_op; Mem_Write_EX_MEM = wr_op; Reg_Write_EX_MEM = rw;
    Mem_to_Reg_EX_MEM = m2r; result_EX_MEM = addr; Write_Data_EX_MEM = wdata;
    rd_EX_MEM = rd; PcSrc_EX_MEM = pcs; zero_EX_MEM = zr; PC_Branch_EX_MEM = pcb;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      dmem_req_ready = dmem_req_valid && (req_c >= A);
      if (acc) dmem_rsp_valid = (wait_c == R);
      else     dmem_rsp_valid = dmem_req_valid ? 1'($urandom_range(0, 1)) : 1'b0;
      dmem_rdata = (acc && wait_c == R) ? rdata : $urandom;
      #1;
      if (cyc == 0) begin
        chk("branch_taken", branch_taken, pcs & zr);
        chk("branch_target", branch_target, pcb);
      end else begin
        chk("bubble_rw", Reg_Write_MEM_WB, 0);
        chk("bubble_m2r", Mem_to_Reg_MEM_WB, 0);
        chk("bubble_rd", rd_MEM_WB, 0);
      end
      if (dmem_req_valid) begin
        chk("req_addr", dmem_addr, addr);
        chk("req_we", dmem_we, wr_op);
        chk("req_wdata", dmem_wdata, wdata);
        if (dmem_req_ready) accepts++;
      end else chk("we_idle", dmem_we, 0);
      if (stall_mem) begin
        stalls++;
        chk("fault_stalled", mem_fault, 0);
      end else begin
        chk("mem_fault", mem_fault, exp_fault);
        done = 1;
      end
      if (dmem_req_valid) begin
        req_c++;
        if (dmem_req_ready) acc = 1;
      end else if (acc) wait_c++;
    end
    if (!done) chk("op_bound", 0, 1);
    chk("stall_cycles", stalls, exp_stalls);
    chk("accepts", accepts, (exp_mem && !mis) ? 1 : 0);
    @(posedge clk); #1;
    dmem_req_ready = 0; dmem_rsp_valid = 0;
    chk("wb_rw", Reg_Write_MEM_WB, rw & ~exp_fault);
    chk("wb_m2r", Mem_to_Reg_MEM_WB, m2r);
    chk("wb_rd", rd_MEM_WB, rd);
    chk("wb_result", result_MEM_WB, addr);
    chk("wb_rdata", read_data_MEM_WB, (rd_op && !exp_fault) ? rdata : 32'h0);
    chk("fault_after", mem_fault, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, stall_mem, 0);
    chk({tag, "_req"}, dmem_req_valid, 0);
    chk({tag, "_fault"}, mem_fault, 0);
    chk({tag, "_rw"}, Reg_Write_MEM_WB, 0);
    chk({tag, "_m2r"}, Mem_to_Reg_MEM_WB, 0);
    chk({tag, "_rdata"}, read_data_MEM_WB, 0);
    chk({tag, "_result"}, result_MEM_WB, 0);
    chk({tag, "_rd"}, rd_MEM_WB, 0);
  endtask

  initial begin
    logic rdo, m2r;
    logic [31:0] a;
    int A, R;
    rst = 1; idle_bundle();
    repeat (3) @(posedge clk);
    #1; check_all_zero("reset");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // directed: ALU op, load, store, misaligned load, timeout, last-cycle response
    run_op(0, 0, 1, 0, 32'h1234, 0, 5'd5, 0, 0, 0);
    run_op(1, 0, 1, 1, 32'h100, 0, 5'd7, 2, 3, 32'hDEADBEEF);
    run_op(0, 1, 0, 0, 32'h200, 32'hCAFEF00D, 5'd0, 0, 0, 0);
    run_op(1, 0, 1, 1, 32'h102, 0, 5'd9, 0, 0, 32'h11111111);
    run_op(1, 0, 1, 1, 32'h300, 0, 5'd3, 1, 1000, 32'h22222222);
    run_op(1, 0, 1, 1, 32'h304, 0, 5'd4, 0, TO - 1, 32'h33333333);

    // reset in the middle of WAIT
    Mem_Read_EX_MEM = 1; Reg_Write_EX_MEM = 1; result_EX_MEM = 32'h400; rd_EX_MEM = 5'd2;
    @(negedge clk);
    @(negedge clk); dmem_req_ready = 1;
    @(negedge clk); dmem_req_ready = 0;
    @(negedge clk);
    rst = 1; idle_bundle();
    repeat (2) @(posedge clk);
    #1; check_all_zero("mid_reset");
    @(negedge clk); rst = 0; dmem_rsp_valid = 1; dmem_rdata = 32'h55555555;
    @(posedge clk); #1;
    dmem_rsp_valid = 0;
    chk("post_reset_rw", Reg_Write_MEM_WB, 0);
    chk("post_reset_rdata", read_data_MEM_WB, 0);
    chk("post_reset_stall", stall_mem, 0);

    // randomized mix
    for (int i = 0; i < 150; i++) begin
      int kind = $urandom_range(0, 2);
      rdo = (kind == 1);
      m2r = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      A = $urandom_range(0, 3);
      R = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 3, TO + 3) : $urandom_range(0, 6);
      run_op(rdo, kind == 2, 1'($urandom_range(0, 1)), m2r, a, $urandom,
             5'($urandom_range(0, 31)), A, R, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register in the 5-stage RV32 core.
- Takes the EX_MEM bundle and runs the load/store on a valid/ready data-memory bus with variable latency.
- Stalls the upstream pipeline while the access is in flight, resolves branches, and holds the MEM/WB pipeline register that feeds write-back.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT before a read is abandoned with a fault.
- CNT_W, 7: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Mem_Read_EX_MEM  in  1  load in the MEM stage.
- Mem_Write_EX_MEM  in  1  store in the MEM stage.
- PcSrc_EX_MEM  in  1  branch instruction flag.
- zero_EX_MEM  in  1  ALU zero flag.
- Mem_to_Reg_EX_MEM  in  1  write-back source select.
- Reg_Write_EX_MEM  in  1  register write enable.
- PC_Branch_EX_MEM  in  32  branch target.
- result_EX_MEM  in  32  ALU result, also the memory address.
- Write_Data_EX_MEM  in  32  store data.
- rd_EX_MEM  in  5  destination register.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  store data.
- dmem_rsp_valid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- stall_mem  out  1  hold PC, IF_ID, ID_EX and EX_MEM this cycle.
- branch_taken  out  1  PcSrc_EX_MEM AND zero_EX_MEM.
- branch_target  out  32  equals PC_Branch_EX_MEM.
- Reg_Write_MEM_WB  out  1  registered.
- Mem_to_Reg_MEM_WB  out  1  registered.
- read_data_MEM_WB  out  32  registered.
- result_MEM_WB  out  32  registered.
- rd_MEM_WB  out  5  registered.
- mem_fault  out  1  one-cycle pulse on misalign or timeout.

Behaviour:
- mem_op = Mem_Read_EX_MEM OR Mem_Write_EX_MEM.
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- On rst: every registered output, the counter, and the captured read data are cleared to 0. Applies mid-operation (REQ/WAIT) too: the request is dropped and the FSM returns to IDLE.
- IDLE:
  - mem_op=0: stall_mem=0; the bundle passes to MEM/WB at the next edge (1-cycle latency).
  - mem_op=1, result[1:0]==0: stall_mem=1, next state REQ.
  - mem_op=1, result[1:0]!=0: stall_mem=1, next state DONE with the fault flag set; no bus request is issued.
- REQ:
  - dmem_req_valid=1; dmem_we=Mem_Write; dmem_addr=result; dmem_wdata=Write_Data. These stay stable until accepted (inputs are held by the stall). stall_mem=1.
  - On dmem_req_ready: write goes to DONE (posted, no response expected); read goes to WAIT with the counter cleared.
  - dmem_rsp_valid in REQ is ignored; memory responds no earlier than 1 cycle after accept.
- WAIT:
  - stall_mem=1; the counter increments each cycle.
  - dmem_rsp_valid=1: capture dmem_rdata, go to DONE.
  - Otherwise, counter==TIMEOUT_CYCLES-1: captured data=0, fault flag set, go to DONE.
  - If rsp_valid and timeout occur in the same cycle, the response wins.
- DONE:
  - stall_mem=0; mem_fault=fault flag; next state IDLE.
  - MEM/WB loads the bundle plus the captured data at this edge.
  - The same instruction is never re-issued, because DONE always exits to IDLE.
- dmem_req_valid=0 and dmem_we=0 outside REQ. dmem_rsp_valid outside WAIT is ignored.
- MEM/WB register:
  - stall_mem=0: loads Reg_Write, Mem_to_Reg, result, rd, and read data. read_data is the captured data after a load, otherwise 0.
  - stall_mem=1: loads a bubble (Reg_Write=0, Mem_to_Reg=0, rd=0), so write-back never repeats.
  - On a fault, Reg_Write_MEM_WB is forced to 0.
- branch_taken and branch_target are combinational and independent of the FSM. Branches are never mem ops.

Test Plan:
- Reset: drive rst=1 for 2 cycles during WAIT, then release → IDLE; all outputs 0; a later rsp_valid is ignored, Reg_Write_MEM_WB=0.
- ALU op: Reg_Write=1, rd=5, result=0x1234, no mem op → next cycle Reg_Write_MEM_WB=1, rd_MEM_WB=5, result_MEM_WB=0x1234; stall_mem never asserted.
- Load: addr 0x100, req_ready after 2 cycles, rsp_valid 3 cycles later with rdata=0xDEADBEEF → stall_mem high for 1+2+3+... cycles until DONE; one DONE cycle; read_data_MEM_WB=0xDEADBEEF, Mem_to_Reg_MEM_WB=1; bubbles before it.
- Store: addr 0x200, wdata 0xCAFEF00D, req_ready immediate → exactly one accepted request with we=1; FSM goes IDLE→REQ→DONE; no WAIT.
- Misaligned load: addr 0x102 → no dmem_req_valid; mem_fault pulses 1 cycle; Reg_Write_MEM_WB=0.
- Timeout: read accepted with no response, TIMEOUT_CYCLES=64 → DONE after 64 WAIT cycles; mem_fault=1; read_data=0. Repeat with rsp_valid on the last WAIT cycle → data captured, no fault.
